// File: rtl/mul_sequencer.sv
// Sequential radix-2 shift-add multiplier (MUL / UMULL / SMULL) with fixed WIDTH-cycle latency.
// Define MUL_SIGNED_EN to build SMULL sign handling; without it op=11 behaves as UMULL.
module mul_sequencer #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] hi
);
   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state, state_next;
   logic               accept, last;
   logic [CW-1:0]      cnt;
   logic [WIDTH-1:0]   mcand, mag_a, mag_b;
   logic [2*WIDTH:0]   acc, acc_step;
   logic [WIDTH:0]     upper;
   logic [2*WIDTH-1:0] result;
   logic               is_mul;
`ifdef MUL_SIGNED_EN
   logic               neg, neg_in;
`endif

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      accept     = 1'b0;
      last       = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            accept = start;
            if (start) state_next = RUN;
         end
         RUN: begin
            busy = 1'b1;
            last = (cnt == CW'(WIDTH - 1));
            if (last) state_next = DONE;
         end
         DONE: begin
            done       = 1'b1;
            accept     = start;
            state_next = start ? RUN : IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Two's-complement magnitude; the most-negative value maps to 2^(WIDTH-1) as unsigned.
   always_comb begin
      mag_a = a;
      mag_b = b;
`ifdef MUL_SIGNED_EN
      neg_in = 1'b0;
      if (op == 2'b11) begin
         if (a[WIDTH-1]) mag_a = -a;
         if (b[WIDTH-1]) mag_b = -b;
         neg_in = a[WIDTH-1] ^ b[WIDTH-1];
      end
`endif
   end

   // acc = {carry, partial product, remaining multiplier bits}; add then shift right.
   always_comb begin
      upper = acc[2*WIDTH:WIDTH];
      if (acc[0]) upper = upper + {1'b0, mcand};
      acc_step = {upper, acc[WIDTH-1:0]} >> 1;
      result   = acc_step[2*WIDTH-1:0];
`ifdef MUL_SIGNED_EN
      if (neg) result = -result;
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt    <= '0;
         mcand  <= '0;
         acc    <= '0;
         is_mul <= 1'b0;
         lo     <= '0;
         hi     <= '0;
`ifdef MUL_SIGNED_EN
         neg    <= 1'b0;
`endif
      end else if (accept) begin
         cnt    <= '0;
         mcand  <= mag_a;
         acc    <= {{(WIDTH + 1){1'b0}}, mag_b};
         is_mul <= (op == 2'b00) || (op == 2'b01);
`ifdef MUL_SIGNED_EN
         neg    <= neg_in;
`endif
      end else if (state == RUN) begin
         acc <= acc_step;
         cnt <= cnt + CW'(1);
         if (last) begin
            lo <= result[WIDTH-1:0];
            hi <= is_mul ? '0 : result[2*WIDTH-1:WIDTH];
         end
      end
   end
endmodule

// File: tb/tb_mul_sequencer.sv
// Self-checking bench for mul_sequencer: directed corner cases plus randomized ops vs. an arithmetic model.
module tb_mul_sequencer;
   logic        clk = 1'b0;
   logic        reset, start;
   logic [1:0]  op;
   logic [31:0] a, b;
   logic        busy, done;
   logic [31:0] lo, hi;
   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mul_sequencer #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .done(done), .lo(lo), .hi(hi)
   );

   // Reference: full-width integer products, truncated/selected per operation.
   function automatic logic [63:0] ref_mul(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      logic [63:0] ux, uy, sx, sy, p;
      ux = {32'd0, x};
      uy = {32'd0, y};
      sx = {{32{x[31]}}, x};
      sy = {{32{y[31]}}, y};
      p  = ux * uy;
      if (o == 2'b10) return p;
      if (o == 2'b11) begin
`ifdef MUL_SIGNED_EN
         return sx * sy;
`else
         return p;
`endif
      end
      return {32'd0, p[31:0]};
   endfunction

   // Issue one op (start held for exactly one edge); return cycles until done and busy count.
   task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int lat, output int busy_n, output logic [31:0] rlo, output logic [31:0] rhi);
      op = o; a = x; b = y; start = 1'b1;
      @(negedge clk);
      start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
      lat = 0;
      busy_n = busy ? 1 : 0;
      while (done !== 1'b1 && lat < 200) begin
         @(negedge clk);
         lat++;
         if (busy === 1'b1) busy_n++;
      end
      rlo = lo; rhi = hi;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b1; op = 2'b10; a = 32'd3; b = 32'd5;
      repeat (3) @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
      checks++; if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo: got %h expected 0", lo); end
      checks++; if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi: got %h expected 0", hi); end
      reset = 1'b0; start = 1'b0;
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", busy); end
   endtask

   task automatic test_mul_basic();
      int lat, bn; logic [31:0] rl, rh;
      do_op(2'b00, 32'd3, 32'd5, lat, bn, rl, rh);
      checks++; if (lat !== 32) begin errors++; $display("FAIL basic_latency: got %0d expected 32", lat); end
      checks++; if (bn !== 32) begin errors++; $display("FAIL basic_busy_cycles: got %0d expected 32", bn); end
      checks++; if (rl !== 32'h0000000F) begin errors++; $display("FAIL basic_lo: got %h expected 0000000f", rl); end
      checks++; if (rh !== 32'd0) begin errors++; $display("FAIL basic_hi: got %h expected 0", rh); end
      @(negedge clk);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_pulse_width: got %b expected 0", done); end
      checks++; if (lo !== 32'h0000000F) begin errors++; $display("FAIL lo_hold: got %h expected 0000000f", lo); end
   endtask

   task automatic test_vectors();
      logic [1:0]  vo[7] = '{2'b10, 2'b11, 2'b11, 2'b00, 2'b01, 2'b11, 2'b10};
      logic [31:0] va[7] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h7FFFFFFF, 32'h0};
      logic [31:0] vb[7] = '{32'hFFFFFFFF, 32'h00000002, 32'h80000000, 32'hFFFFFFFF, 32'h12345, 32'h80000000, 32'h0};
      int lat, bn; logic [31:0] rl, rh; logic [63:0] exp;
      for (int i = 0; i < 7; i++) begin
         do_op(vo[i], va[i], vb[i], lat, bn, rl, rh);
         exp = ref_mul(vo[i], va[i], vb[i]);
         checks++; if (lat !== 32) begin errors++; $display("FAIL vec%0d_latency: got %0d expected 32", i, lat); end
         checks++; if ({rh, rl} !== exp) begin errors++; $display("FAIL vec%0d_result: got %h_%h expected %h", i, rh, rl, exp); end
         @(negedge clk);
      end
   endtask

   task automatic test_ignore_start();
      int lat, bn; logic [31:0] rl, rh; logic [31:0] x, y;
      op = 2'b10; a = 32'd7; b = 32'd9; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 0;
      repeat (9) begin @(negedge clk); lat++; end
      op = 2'b00; a = 32'd2; b = 32'd2; start = 1'b1;
      @(negedge clk); lat++;
      start = 1'b0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ignore_busy: got %b expected 1", busy); end
      while (done !== 1'b1 && lat < 200) begin @(negedge clk); lat++; end
      checks++; if (lat !== 32) begin errors++; $display("FAIL ignore_latency: got %0d expected 32", lat); end
      checks++; if (lo !== 32'h3F) begin errors++; $display("FAIL ignore_lo: got %h expected 0000003f", lo); end
      checks++; if (hi !== 32'd0) begin errors++; $display("FAIL ignore_hi: got %h expected 0", hi); end
      x = $urandom; y = $urandom;
      op = 2'b10; a = x; b = y; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL b2b_accept: got busy=%b done=%b expected busy=1 done=0", busy, done); end
      lat = 0;
      while (done !== 1'b1 && lat < 200) begin @(negedge clk); lat++; end
      checks++; if (lat !== 32) begin errors++; $display("FAIL b2b_latency: got %0d expected 32", lat); end
      checks++; if ({hi, lo} !== ref_mul(2'b10, x, y)) begin errors++; $display("FAIL b2b_result: got %h_%h expected %h", hi, lo, ref_mul(2'b10, x, y)); end
      @(negedge clk);
   endtask

   task automatic test_reset_abort();
      int lat, bn, pulses; logic [31:0] rl, rh;
      op = 2'b00; a = 32'd6; b = 32'd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
      checks++; if (lo !== 32'd0 || hi !== 32'd0) begin errors++; $display("FAIL abort_lohi: got %h_%h expected 0", hi, lo); end
      pulses = 0;
      repeat (40) begin @(negedge clk); if (done !== 1'b0) pulses++; end
      checks++; if (pulses !== 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses expected 0", pulses); end
      do_op(2'b00, 32'd6, 32'd7, lat, bn, rl, rh);
      checks++; if (lat !== 32) begin errors++; $display("FAIL abort_retry_latency: got %0d expected 32", lat); end
      checks++; if (rl !== 32'h2A || rh !== 32'd0) begin errors++; $display("FAIL abort_retry_result: got %h_%h expected 0_2a", rh, rl); end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int lat, bn; logic [31:0] rl, rh, x, y; logic [1:0] o;
      for (int i = 0; i < 8; i++) begin
         o = 2'($urandom); x = $urandom; y = $urandom;
         do_op(o, x, y, lat, bn, rl, rh);
         checks++; if (lat !== 32) begin errors++; $display("FAIL b2b%0d_latency: got %0d expected 32", i, lat); end
         checks++; if ({rh, rl} !== ref_mul(o, x, y)) begin errors++; $display("FAIL b2b%0d_result op=%0d a=%h b=%h: got %h_%h expected %h", i, o, x, y, rh, rl, ref_mul(o, x, y)); end
      end
      @(negedge clk);
   endtask

   task automatic test_random();
      int lat, bn; logic [31:0] rl, rh, x, y; logic [1:0] o;
      logic [31:0] corner[5] = '{32'h0, 32'h1, 32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFF};
      for (int i = 0; i < 60; i++) begin
         o = 2'($urandom);
         x = ($urandom_range(3, 0) == 0) ? corner[$urandom_range(4, 0)] : $urandom;
         y = ($urandom_range(3, 0) == 0) ? corner[$urandom_range(4, 0)] : $urandom;
         do_op(o, x, y, lat, bn, rl, rh);
         checks++; if (lat !== 32 || bn !== 32) begin errors++; $display("FAIL rand%0d_timing: got lat=%0d busy=%0d expected 32/32", i, lat, bn); end
         checks++; if ({rh, rl} !== ref_mul(o, x, y)) begin errors++; $display("FAIL rand%0d_result op=%0d a=%h b=%h: got %h_%h expected %h", i, o, x, y, rh, rl, ref_mul(o, x, y)); end
         repeat ($urandom_range(2, 0)) @(negedge clk);
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
      test_reset();
      test_mul_basic();
      test_vectors();
      test_ignore_start();
      test_reset_abort();
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/mul_sequencer.md
MUL_SEQUENCER -- requirements
Module: mul_sequencer

Interface
REQ-001 Parameter: WIDTH, 32, operand width in bits; results are 2*WIDTH wide, split into lo/hi.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request a multiply; sampled only when the block can accept.
REQ-005 op  input  2  operation: 00 MUL, 01 MUL (alias), 10 UMULL, 11 SMULL.
REQ-006 a  input  WIDTH  multiplicand, captured on the accepting edge.
REQ-007 b  input  WIDTH  multiplier, captured on the accepting edge.
REQ-008 busy  output  1  high while an operation is iterating.
REQ-009 done  output  1  one-cycle pulse; lo/hi valid.
REQ-010 lo  output  WIDTH  low half of the product.
REQ-011 hi  output  WIDTH  high half of the product; 0 for MUL.

Function
REQ-012 The block SHALL be an FSM with states IDLE, RUN and DONE; busy = (state==RUN) and done = (state==DONE).
REQ-013 start SHALL be accepted only in IDLE or DONE; on the accepting edge the block captures a, b and op, clears its step counter and enters RUN.
REQ-014 start SHALL be ignored in RUN, with no effect on the operation in progress.
REQ-015 Each RUN edge SHALL perform one radix-2 shift-add step on the captured magnitudes and increment the step counter.
REQ-016 The step on counter value WIDTH-1 SHALL be the last; the FSM then enters DONE.
REQ-017 Latency SHALL be fixed: done is high in the cycle following the edge WIDTH edges after the accepting edge, independent of operand values (no early termination on zero operands).
REQ-018 DONE SHALL last one cycle: next edge goes to RUN if start=1, else IDLE.
REQ-019 lo/hi SHALL be written only on the edge entering DONE and hold until the next such edge or reset.
REQ-020 MUL: lo = low WIDTH bits of a*b; hi = 0.
REQ-021 UMULL: {hi,lo} = unsigned a*b, full 2*WIDTH bits.
REQ-022 SMULL: multiply the two's-complement magnitudes unsigned; negate the 2*WIDTH result when a[WIDTH-1]^b[WIDTH-1]=1.
REQ-023 The most-negative operand (e.g. 0x80000000) SHALL have magnitude 2^(WIDTH-1) with no overflow.
REQ-024 Internal accumulator SHALL be 2*WIDTH+1 bits so that no carry is lost in any step.

Reset
REQ-025 While reset=1 at an edge: state=IDLE, counter=0, lo=0, hi=0; busy=0 and done=0.
REQ-026 Reset SHALL take priority over start, including during RUN; an aborted operation produces no done pulse and no lo/hi update.

Configuration
REQ-027 Macro MUL_SIGNED_EN defined: SMULL is implemented as specified in REQ-022 and REQ-023.
REQ-028 Macro MUL_SIGNED_EN undefined: no sign/negate logic is built, and op=11 behaves exactly as UMULL.

Verification
REQ-029 MUL a=3, b=5, start pulsed at edge 0 -> done=1 for exactly one cycle after edge 32, lo=0x0000000F, hi=0, busy=1 during the preceding 32 cycles.
REQ-030 UMULL a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-031 SMULL a=0xFFFFFFFF, b=0x00000002 -> with MUL_SIGNED_EN: hi=0xFFFFFFFF, lo=0xFFFFFFFE; without it: hi=0x00000001, lo=0xFFFFFFFE.
REQ-032 SMULL a=0x80000000, b=0x80000000 (MUL_SIGNED_EN) -> hi=0x40000000, lo=0x00000000.
REQ-033 Start UMULL 7*9, then pulse start with MUL 2*2 at edge 10 -> result still hi=0, lo=0x3F with done at the original time; then assert start in the DONE cycle -> second op accepted back-to-back with busy=1 next cycle.
REQ-034 Start MUL 6*7, assert reset at edge 10 -> busy=0, done never pulses, lo=hi=0; a new MUL 6*7 afterwards -> lo=0x2A with full 32-cycle latency.
